// File: rtl/syn_counter_pkg.sv
// Shared constants and elaboration helpers for the synchronous up-counter slice.
package syn_counter_pkg;

  localparam int DEF_WIDTH   = 4;
  localparam int DEF_MODULUS = 16;

  // Terminal count MODULUS-1; callers narrow it to their own width.
  function automatic logic [15:0] term_value(input int modulus);
    return 16'(modulus - 1);
  endfunction

  function automatic bit modulus_ok(input int width, input int modulus);
    return (width >= 1) && (width <= 16) && (modulus >= 2) && (modulus <= (1 << width));
  endfunction

endpackage

// File: rtl/syn_up_counter_if.sv
// Control/data bundle of one counter stage. Index 0 of DIN/QOUT is the MSB.
interface syn_up_counter_if
  import syn_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();
  logic             EN;
  logic             CIN;
  logic             LOAD;
  logic [0:WIDTH-1] DIN;
  logic [0:WIDTH-1] QOUT;
  logic             COUT;
  logic             WRAP;

  modport master (output EN, CIN, LOAD, DIN, input  QOUT, COUT, WRAP);
  modport slave  (input  EN, CIN, LOAD, DIN, output QOUT, COUT, WRAP);
endinterface

// File: rtl/syn_tcell.sv
// One counter bit: toggle flip-flop with synchronous load and async active-high clear.
module syn_tcell (
  input  logic CLK,
  input  logic RESET,
  input  logic T,
  input  logic LD,
  input  logic D,
  output logic Q
);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)   Q <= 1'b0;
    else if (LD) Q <= D;
    else if (T)  Q <= ~Q;
  end

endmodule

// File: rtl/syn_up_counter.sv
// Cascadable synchronous modulo-N up counter built from toggle cells; all bits
// advance on the same CLK edge, stages chain through COUT -> CIN.
module syn_up_counter
  import syn_counter_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic             CLK,
  input  logic             RESET,
  syn_up_counter_if.slave  bus
);

  localparam logic [0:WIDTH-1] TERM = WIDTH'(term_value(MODULUS));
  localparam bit               FULL = (MODULUS == (1 << WIDTH));

  if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_params
    $error("syn_up_counter: MODULUS must be in 2..2**WIDTH and WIDTH in 1..16");
  end

  logic [0:WIDTH-1] q;
  logic [0:WIDTH-1] t;
  logic [0:WIDTH-1] d;
  logic             cnt;
  logic             at_term;
  logic             clr;
  logic             ld;
  logic             wrap_q;

  assign cnt     = bus.EN & bus.CIN & ~bus.LOAD;
  assign at_term = (q == TERM);

  // Power-of-two modulus wraps by natural toggle; otherwise the terminal state
  // is cleared through the cells' synchronous load path.
  assign clr = !FULL && cnt && at_term;
  assign ld  = bus.LOAD | clr;
  assign d   = (bus.LOAD && (32'(bus.DIN) < MODULUS)) ? bus.DIN : '0;

  always_comb begin
    t            = '0;
    t[WIDTH-1]   = 1'b1;
    for (int i = WIDTH - 2; i >= 0; i--)
      t[i] = t[i+1] & q[i+1];
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    syn_tcell u_cell (
      .CLK   (CLK),
      .RESET (RESET),
      .T     (cnt & t[i]),
      .LD    (ld),
      .D     (d[i]),
      .Q     (q[i])
    );
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) wrap_q <= 1'b0;
    else       wrap_q <= cnt & at_term;
  end

  assign bus.QOUT = q;
  assign bus.COUT = bus.EN & bus.CIN & at_term;
  assign bus.WRAP = wrap_q;

endmodule

// File: tb/tb_syn_up_counter.sv
// Directed bench: hex counter, decade counter and a two-digit decade cascade.
module tb_syn_up_counter;

  logic CLK;
  logic RESET;
  int   nvec;
  int   nerr;

  syn_up_counter_if #(.WIDTH(4)) a_if ();
  syn_up_counter_if #(.WIDTH(4)) b_if ();
  syn_up_counter_if #(.WIDTH(4)) lo_if ();
  syn_up_counter_if #(.WIDTH(4)) hi_if ();

  syn_up_counter #(.WIDTH(4), .MODULUS(16)) u_hex (.CLK(CLK), .RESET(RESET), .bus(a_if));
  syn_up_counter #(.WIDTH(4), .MODULUS(10)) u_dec (.CLK(CLK), .RESET(RESET), .bus(b_if));
  syn_up_counter #(.WIDTH(4), .MODULUS(10)) u_lo  (.CLK(CLK), .RESET(RESET), .bus(lo_if));
  syn_up_counter #(.WIDTH(4), .MODULUS(10)) u_hi  (.CLK(CLK), .RESET(RESET), .bus(hi_if));

  assign hi_if.CIN = lo_if.COUT;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    nvec  = 0;
    nerr  = 0;
    RESET = 1'b1;
    a_if.EN = 0;  a_if.CIN = 1;  a_if.LOAD = 0;  a_if.DIN = '0;
    b_if.EN = 0;  b_if.CIN = 1;  b_if.LOAD = 0;  b_if.DIN = '0;
    lo_if.EN = 0; lo_if.CIN = 1; lo_if.LOAD = 0; lo_if.DIN = '0;
    hi_if.EN = 0;                hi_if.LOAD = 0; hi_if.DIN = '0;
    #2;
    chk("rst_q",    a_if.QOUT, 0);
    chk("rst_wrap", a_if.WRAP, 0);
    chk("rst_cout", a_if.COUT, 0);
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;

    // Load 9, then hit RESET mid-cycle while counting is enabled.
    a_if.LOAD = 1; a_if.DIN = 4'd9;
    tick();
    a_if.LOAD = 0;
    chk("load9", a_if.QOUT, 9);
    a_if.EN = 1;
    #3 RESET = 1'b1;
    #1;
    chk("async_rst_q",    a_if.QOUT, 0);
    chk("async_rst_wrap", a_if.WRAP, 0);
    #1 RESET = 1'b0;

    // Free run 1..15,0.
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk("hex_q",    a_if.QOUT, k % 16);
      chk("hex_wrap", a_if.WRAP, (k == 16) ? 1 : 0);
      chk("hex_cout", a_if.COUT, ((k % 16) == 15) ? 1 : 0);
    end
    a_if.EN = 0;
    tick();
    chk("hex_wrap_drop", a_if.WRAP, 0);

    // LOAD beats count.
    a_if.LOAD = 1; a_if.DIN = 4'd15;
    tick();
    chk("load15", a_if.QOUT, 15);
    a_if.DIN = 4'd3; a_if.EN = 1;
    tick();
    chk("prio_q",    a_if.QOUT, 3);
    chk("prio_wrap", a_if.WRAP, 0);

    // Gating with QOUT = 5.
    a_if.EN = 0; a_if.DIN = 4'd5;
    tick();
    a_if.LOAD = 0;
    chk("load5", a_if.QOUT, 5);
    repeat (4) begin
      tick();
      chk("en0_hold", a_if.QOUT, 5);
    end
    a_if.EN = 1; a_if.CIN = 0;
    repeat (4) begin
      tick();
      chk("cin0_hold", a_if.QOUT, 5);
      chk("cin0_cout", a_if.COUT, 0);
    end
    a_if.LOAD = 1; a_if.DIN = 4'd15;
    tick();
    a_if.LOAD = 0;
    chk("cin0_term_cout", a_if.COUT, 0);
    tick();
    chk("cin0_term_hold", a_if.QOUT, 15);
    a_if.EN = 0; a_if.CIN = 1;

    // Decade counter.
    b_if.EN = 1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk("dec_q",    b_if.QOUT, k % 10);
      chk("dec_wrap", b_if.WRAP, ((k % 10) == 0) ? 1 : 0);
      chk("dec_cout", b_if.COUT, ((k % 10) == 9) ? 1 : 0);
    end
    b_if.EN = 0; b_if.LOAD = 1; b_if.DIN = 4'd12;
    tick();
    chk("dec_load12", b_if.QOUT, 0);
    b_if.DIN = 4'd9;
    tick();
    chk("dec_load9",      b_if.QOUT, 9);
    chk("dec_load9_wrap", b_if.WRAP, 0);
    b_if.LOAD = 0; b_if.EN = 1;
    tick();
    chk("dec_wrap_q",  b_if.QOUT, 0);
    chk("dec_wrap_pl", b_if.WRAP, 1);
    tick();
    chk("dec_after_q",    b_if.QOUT, 1);
    chk("dec_after_wrap", b_if.WRAP, 0);
    b_if.EN = 0;

    // Two-digit cascade 00..99 -> 00.
    lo_if.EN = 1; hi_if.EN = 1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("cas_lo",     lo_if.QOUT, (k % 100) % 10);
      chk("cas_hi",     hi_if.QOUT, (k % 100) / 10);
      chk("cas_hi_wrp", hi_if.WRAP, (k == 100) ? 1 : 0);
    end
    lo_if.EN = 0; hi_if.EN = 0;
    tick();
    chk("cas_hi_wrap_drop", hi_if.WRAP, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/syn_up_counter.md
# syn_up_counter

Synchronous, cascadable modulo-N up counter, the incrementing counterpart of the lab's synchronous down counter. All bits advance on the same CLK edge using toggle-enable logic: bit i toggles when every less-significant bit is 1. Adds count enable, parallel load, carry-in/carry-out for chaining stages, and a registered wrap pulse. It serves as the counting element for the lab's timers and display-digit chains.

## Interface
Parameters:
- WIDTH, 4: counter width in bits, 1..16.
- MODULUS, 16: count sequence length, 2..2^WIDTH. Count runs 0 .. MODULUS-1.

Ports:
- CLK  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- EN  in  1  count enable.
- CIN  in  1  cascade carry-in. Tie to 1 on the least-significant stage.
- LOAD  in  1  synchronous parallel load.
- DIN  in  [0:WIDTH-1]  load value. Index 0 is the MSB.
- QOUT  out  [0:WIDTH-1]  current count. Index 0 is the MSB, index WIDTH-1 the LSB.
- COUT  out  1  combinational carry-out: EN & CIN & (QOUT == MODULUS-1).
- WRAP  out  1  registered one-cycle pulse following a wrap to 0.

## Operation
- Reset values:
  - QOUT = 0 and WRAP = 0 while RESET is high, independent of CLK.
  - COUT follows from QOUT, so it is 0 during reset.
- Priority on each rising CLK edge: RESET, then LOAD, then count, then hold.
- LOAD = 1:
  - QOUT <= DIN if DIN < MODULUS; otherwise QOUT <= 0.
  - LOAD ignores EN and CIN, and WRAP <= 0.
- Count occurs when LOAD = 0, EN = 1 and CIN = 1:
  - If QOUT == MODULUS-1: QOUT <= 0 and WRAP <= 1.
  - Otherwise: QOUT <= QOUT + 1 and WRAP <= 0.
- Hold (EN = 0 or CIN = 0): QOUT unchanged, WRAP <= 0.
- Increment is implemented as per-bit toggle enables:
  - t[WIDTH-1] = 1.
  - t[i] = t[i+1] & QOUT[i+1].
  - When MODULUS = 2^WIDTH, the terminal compare collapses to all-ones and wrap is the natural toggle.
  - For any other MODULUS, the terminal state forces a synchronous clear.
- Cascade: the COUT of stage k drives the CIN of stage k+1. All stages share CLK, EN and RESET, so the chain stays fully synchronous with no ripple clocking.

## Timing
- QOUT and WRAP update 1 cycle after a qualifying edge. Latency from EN/LOAD to QOUT is 1 clock.
- COUT is zero-latency combinational from QOUT, EN and CIN. The cascade path is an AND chain of depth equal to the number of stages.
- Boundary conditions:
  - Wrap: the edge from MODULUS-1 to 0 asserts WRAP for exactly the next cycle. Back-to-back wraps are only possible with MODULUS = 2 and EN held high; WRAP then pulses every other cycle.
  - LOAD and count requested together: LOAD wins, with no increment and no WRAP.
  - LOAD of MODULUS-1 with EN = 1: the next counting edge wraps and asserts WRAP.
  - RESET asserted mid-count: QOUT and WRAP go to 0 immediately. After RESET deasserts, the first rising edge counts from 0 if enabled.
  - CIN = 0 with EN = 1: hold, and COUT = 0.

## Structure
- Package syn_counter_pkg holds:
  - the default WIDTH and MODULUS constants;
  - a function computing the terminal value MODULUS-1 at WIDTH bits;
  - an elaboration check that MODULUS <= 2^WIDTH.
- Sub-module syn_tcell holds one toggle flip-flop with an async active-high clear and synchronous load. Inputs are T, LD and D. syn_up_counter instantiates WIDTH of them and generates the toggle-enable chain and the terminal clear.

## Test plan
- Reset and free run: assert RESET mid-cycle with QOUT = 9, EN = 1, CIN = 1, WIDTH = 4, MODULUS = 16.
  - QOUT = 0 asynchronously.
  - After release, QOUT reads 1, 2, …, 15, 0. WRAP is high only in the cycle after the 15→0 edge, and COUT is high while QOUT = 15.
- Decade mode, WIDTH = 4, MODULUS = 10: run 0…9→0 with WRAP once per 10 cycles. Load DIN = 12 → QOUT = 0. Load DIN = 9 → next counting edge gives QOUT = 0 and WRAP = 1.
- Priority: hold QOUT = 15 and apply LOAD = 1, DIN = 3, EN = 1 together → QOUT = 3, WRAP = 0.
- Gating, with QOUT = 5 held 4 cycles in each case:
  - EN = 0 → QOUT stays 5.
  - CIN = 0, EN = 1 → QOUT stays 5 and COUT = 0.
- Cascade: two MODULUS = 10 stages count 00…99→00 with EN = 1.
  - The upper stage increments only on lower-stage COUT.
  - The upper-stage WRAP pulses once, after the 99→00 edge.
